// File: rtl/dram_pkg.sv
// Shared types and helpers for the banked DRAM simulation model.
//   dram_cmd_e  : decoded pin-level command
//   dram_decode : {CSn, RASn, CASn, &WEn} -> command
//   dram_clog2  : ceil(log2(v)), 0 for v <= 1
//   dram_max    : larger of two widths
package dram_pkg;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACT,
    CMD_PRE,
    CMD_RD,
    CMD_WR
  } dram_cmd_e;

  // A column command is a write as soon as any byte lane is enabled.
  function automatic dram_cmd_e dram_decode(input logic cs_n, input logic ras_n,
                                            input logic cas_n, input logic we_all_n);
    dram_cmd_e cmd;
    cmd = CMD_NOP;
    if (!cs_n) begin
      unique case ({ras_n, cas_n})
        2'b01:   cmd = CMD_ACT;
        2'b00:   cmd = we_all_n ? CMD_RD : CMD_WR;
        2'b10:   cmd = CMD_PRE;
        default: cmd = CMD_NOP;
      endcase
    end
    return cmd;
  endfunction

  function automatic int unsigned dram_clog2(input int unsigned v);
    return (v <= 1) ? 0 : $clog2(v);
  endfunction

  function automatic int unsigned dram_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dram_rd_pipe.sv
// Read-latency delay line: DEPTH stages of {valid, data}.
// The last stage only loads data on a valid beat, so data_o holds the
// previous read beat while valid_o is low.
//   clk_i, rst_ni     : clock, synchronous active-low reset
//   valid_i, data_i   : read beat entering the line
//   valid_o, data_o   : read beat leaving the line (registered)
module dram_rd_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];

  // Shift; last stage holds its data unless a valid beat arrives.
  always_comb begin
    valid_d    = '0;
    valid_d[0] = valid_i;
    data_d[0]  = data_i;
    for (int k = 1; k < DEPTH; k++) begin
      valid_d[k] = valid_q[k-1];
      data_d[k]  = data_q[k-1];
    end
    if (!valid_d[DEPTH-1]) data_d[DEPTH-1] = data_q[DEPTH-1];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/dram_banked.sv
// Multi-bank burst DRAM simulation model with per-bank open-row tracking,
// wrapped fixed-length bursts, programmable CAS latency and protocol-error flag.
//   CK, RSTn            : clock, synchronous active-low reset (clears memory)
//   CSn, RASn, CASn, WEn: command pins (WEn per byte lane, active-low)
//   BA, A, D            : bank, row/column address, write data
//   Q, Q_VALID          : read data and read-beat strobe
//   ERR                 : one-cycle pulse for a rejected command
module dram_banked
  import dram_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned ROW_SIZE  = 11,
  parameter int unsigned COL_SIZE  = 10,
  parameter int unsigned BANK_BITS = 2,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CAS_LAT   = 3,
  parameter int unsigned TRCD      = 2
) (
  input  logic                                    CK,
  input  logic                                    RSTn,
  input  logic                                    CSn,
  input  logic                                    RASn,
  input  logic                                    CASn,
  input  logic [WORD_SIZE/8-1:0]                  WEn,
  input  logic [BANK_BITS-1:0]                    BA,
  input  logic [dram_max(ROW_SIZE, COL_SIZE)-1:0] A,
  input  logic [WORD_SIZE-1:0]                    D,
  output logic [WORD_SIZE-1:0]                    Q,
  output logic                                    Q_VALID,
  output logic                                    ERR
);

  localparam int unsigned BYTES  = WORD_SIZE / 8;
  localparam int unsigned NBANK  = 1 << BANK_BITS;
  localparam int unsigned IDX_W  = BANK_BITS + ROW_SIZE + COL_SIZE;
  localparam int unsigned NWORDS = 1 << IDX_W;
  localparam int unsigned BEAT_W = dram_clog2(BURST_LEN) + 1;
  localparam int unsigned AGE_W  = dram_clog2(TRCD + 2);
  localparam logic [COL_SIZE-1:0] WRAP_MASK = COL_SIZE'(BURST_LEN - 1);

  logic [WORD_SIZE-1:0] mem_q [NWORDS];

  logic [NBANK-1:0]    open_q, open_d;
  logic [ROW_SIZE-1:0] brow_q [NBANK];
  logic [ROW_SIZE-1:0] brow_d [NBANK];
  logic [AGE_W-1:0]    age_q  [NBANK];
  logic [AGE_W-1:0]    age_d  [NBANK];

  logic                 busy_q, busy_d;
  logic                 wr_q, wr_d;
  logic [BANK_BITS-1:0] bank_q, bank_d;
  logic [ROW_SIZE-1:0]  row_q, row_d;
  logic [COL_SIZE-1:0]  base_q, base_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic                 err_q, err_d;
  logic                 rvalid_q, rvalid_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;

  dram_cmd_e            cmd_c;
  logic                 col_cmd_c, col_ok_c;
  logic                 beat_act_c, beat_wr_c, beat_last_c;
  logic [BANK_BITS-1:0] beat_bank_c;
  logic [ROW_SIZE-1:0]  beat_row_c;
  logic [COL_SIZE-1:0]  beat_base_c, beat_col_c;
  logic [BEAT_W-1:0]    beat_idx_c;
  logic [IDX_W-1:0]     beat_addr_c;

  // Command decode, legality and current burst beat (beat 0 on the command edge).
  always_comb begin
    cmd_c       = dram_decode(CSn, RASn, CASn, &WEn);
    col_cmd_c   = (cmd_c == CMD_RD) || (cmd_c == CMD_WR);
    col_ok_c    = col_cmd_c && open_q[BA] && (age_q[BA] >= AGE_W'(TRCD)) && !busy_q;
    beat_act_c  = col_ok_c || busy_q;
    beat_wr_c   = col_ok_c ? (cmd_c == CMD_WR) : wr_q;
    beat_bank_c = col_ok_c ? BA : bank_q;
    beat_row_c  = col_ok_c ? brow_q[BA] : row_q;
    beat_base_c = col_ok_c ? A[COL_SIZE-1:0] : base_q;
    beat_idx_c  = col_ok_c ? '0 : beat_q;
    beat_last_c = (beat_idx_c == BEAT_W'(BURST_LEN - 1));
    // Wrap inside the BURST_LEN-aligned block of the base column.
    beat_col_c  = (beat_base_c & ~WRAP_MASK) |
                  ((beat_base_c + COL_SIZE'(beat_idx_c)) & WRAP_MASK);
    beat_addr_c = {beat_bank_c, beat_row_c, beat_col_c};
  end

  // Next state for bank tracking, burst engine and read capture.
  always_comb begin
    err_d    = ((cmd_c == CMD_ACT) && open_q[BA]) || (col_cmd_c && !col_ok_c);
    open_d   = open_q;
    busy_d   = busy_q;
    wr_d     = wr_q;
    bank_d   = bank_q;
    row_d    = row_q;
    base_d   = base_q;
    beat_d   = beat_q;
    rvalid_d = beat_act_c && !beat_wr_c;
    rdata_d  = mem_q[beat_addr_c];
    for (int b = 0; b < NBANK; b++) begin
      brow_d[b] = brow_q[b];
      age_d[b]  = (age_q[b] < AGE_W'(TRCD)) ? age_q[b] + AGE_W'(1) : age_q[b];
    end

    if ((cmd_c == CMD_ACT) && !open_q[BA]) begin
      open_d[BA] = 1'b1;
      brow_d[BA] = A[ROW_SIZE-1:0];
      age_d[BA]  = AGE_W'(1);
    end
    // Closing a bank leaves any in-flight burst on its latched row.
    if (cmd_c == CMD_PRE) open_d[BA] = 1'b0;

    if (col_ok_c) begin
      wr_d   = (cmd_c == CMD_WR);
      bank_d = BA;
      row_d  = brow_q[BA];
      base_d = A[COL_SIZE-1:0];
    end
    if (beat_act_c) begin
      busy_d = !beat_last_c;
      beat_d = beat_last_c ? '0 : beat_idx_c + BEAT_W'(1);
    end
  end

  always_ff @(posedge CK) begin
    if (!RSTn) begin
      open_q   <= '0;
      busy_q   <= 1'b0;
      wr_q     <= 1'b0;
      bank_q   <= '0;
      row_q    <= '0;
      base_q   <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      for (int b = 0; b < NBANK; b++) begin
        brow_q[b] <= '0;
        age_q[b]  <= '0;
      end
    end else begin
      open_q   <= open_d;
      busy_q   <= busy_d;
      wr_q     <= wr_d;
      bank_q   <= bank_d;
      row_q    <= row_d;
      base_q   <= base_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      brow_q   <= brow_d;
      age_q    <= age_d;
    end
  end

  // Storage: cleared on reset, byte-lane writes on write beats.
  always_ff @(posedge CK) begin
    if (!RSTn) begin
      for (int unsigned w = 0; w < NWORDS; w++) mem_q[IDX_W'(w)] <= '0;
    end else if (beat_act_c && beat_wr_c) begin
      for (int b = 0; b < BYTES; b++) begin
        if (!WEn[b]) mem_q[beat_addr_c][8*b +: 8] <= D[8*b +: 8];
      end
    end
  end

  // rdata_q adds one stage, so the line is CAS_LAT deep after it.
  dram_rd_pipe #(
    .WIDTH(WORD_SIZE),
    .DEPTH(CAS_LAT)
  ) u_rd_pipe (
    .clk_i  (CK),
    .rst_ni (RSTn),
    .valid_i(rvalid_q),
    .data_i (rdata_q),
    .valid_o(Q_VALID),
    .data_o (Q)
  );

  assign ERR = err_q;

endmodule

// File: doc/dram_banked.md
# dram_banked

Multi-bank, burst-capable successor to the single-bank DRAM simulation model, used as the external-memory model in SoC simulation. Adds bank addressing with per-bank open-row tracking, explicit precharge, fixed-length wrapped bursts, programmable CAS latency, a read-valid strobe and a protocol-error flag. Same pin-level command style (CSn/RASn/CASn/WEn), so existing DRAM controllers need only drive BA and honour Q_VALID.

## Interface
- WORD_SIZE, 32, data width; must be a multiple of 8
- ROW_SIZE, 11, row address bits per bank
- COL_SIZE, 10, column address bits
- BANK_BITS, 2, bank address bits (NBANK = 2^BANK_BITS)
- BURST_LEN, 4, beats per access; power of 2, 1..2^COL_SIZE
- CAS_LAT, 3, read latency in cycles, 1..8
- TRCD, 2, minimum cycles from ACT to column command on the same bank
- Derived: BYTES = WORD_SIZE/8, ADDR_SIZE = max(ROW_SIZE, COL_SIZE)

- CK  in  1  clock; all state changes on rising edge
- RSTn  in  1  reset, synchronous, active-low
- CSn  in  1  chip select, active-low
- RASn  in  1  row strobe, active-low
- CASn  in  1  column strobe, active-low
- WEn  in  BYTES  per-byte write enable, active-low
- BA  in  BANK_BITS  bank address
- A  in  ADDR_SIZE  row (ACT) or column (RD/WR) address
- D  in  WORD_SIZE  write data
- Q  out  WORD_SIZE  read data
- Q_VALID  out  1  Q carries a read beat this cycle
- ERR  out  1  one-cycle pulse on protocol violation

## Operation
- Commands decoded at each edge, CSn=0 required; CSn=1 is NOP:
  - ACT: RASn=0, CASn=1 -> open row A[ROW_SIZE-1:0] in bank BA
  - RD: RASn=0, CASn=0, WEn all 1
  - WR: RASn=0, CASn=0, any WEn bit 0
  - PRE: RASn=1, CASn=0 -> close bank BA
  - RASn=1, CASn=1: NOP
- Storage: NBANK x 2^ROW_SIZE x 2^COL_SIZE words, byte-lane arrays; index {BA,row,col}.
- Per bank: open flag, row register, ACT-age counter (saturating at TRCD).
- RD/WR latch bank, its row and base column A[COL_SIZE-1:0]; burst runs BURST_LEN beats at command edge and following edges. Beat i column = upper bits of base unchanged, low log2(BURST_LEN) bits = (base + i) mod BURST_LEN (wrap inside aligned block).
- Write beat i: at edge N+i writes D byte lanes whose WEn bit is 0; beats after the first use D/WEn present at that edge, CSn/RASn/CASn ignored for data. A beat with WEn all 1 writes nothing.
- Read beat i: array read at edge N+i (pre-edge contents) enters the latency line.
- ERR pulses, and the command is ignored, on: ACT to an open bank; RD/WR to a closed bank; RD/WR before TRCD elapsed; RD/WR while a burst is in progress. PRE is always accepted; an in-flight burst continues on its latched row.
- Reset (RSTn=0 at an edge): all banks closed, burst aborted, latency line flushed, memory cleared to 0.

## Timing
- Reset values: Q=0, Q_VALID=0, ERR=0.
- RD at edge N: beat i on Q with Q_VALID=1 after edge N+CAS_LAT+i; Q holds last value with Q_VALID=0 otherwise. Default CAS_LAT=3 matches legacy model latency.
- Back-to-back bursts: next RD/WR legal at edge N+BURST_LEN; reads are then gapless on Q.
- ACT at edge M: RD/WR legal from edge M+TRCD.
- ERR asserted for the cycle after the offending edge.
- RD at the edge after the final write beat to the same address returns new data.
- Reset mid-burst: remaining beats dropped, Q_VALID=0 from the next cycle.

## Structure
- Package dram_pkg: command enum (NOP, ACT, PRE, RD, WR), decode function from {CSn,RASn,CASn,&WEn}, clog2 helpers.
- Sub-module dram_rd_pipe: CAS_LAT-deep {valid, data} delay line, synchronous active-low reset.

## Test plan
- Reset, ACT bank0 row 5, wait 2, WR col 0 D=0x11,0x22,0x33,0x44; RD col 0 -> Q_VALID 3 cycles later, Q=0x11,0x22,0x33,0x44.
- RD col 2 of same row -> wrapped order 0x33,0x44,0x11,0x22.
- WR with WEn=4'b1110 beat 0 D=0xAABBCCDD over 0x11 -> reads back 0x000000DD... wait, i.e. only byte0 changed: 0x000000DD.
- ACT bank1 then RD one cycle later -> ERR=1, Q_VALID stays 0; ACT to already-open bank0 -> ERR=1.
- PRE bank0 then RD bank0 -> ERR=1; ACT row 6 bank0 and bank1 row 5, cross-bank reads return independent data.
- RSTn low mid read burst -> Q=0, Q_VALID=0 next cycle; subsequent RD after ACT returns 0.
